// File: rtl/wca_rbus_pkg.sv
// ---------------------------------------------------------------------------
// wca_rbus_pkg
// Shared definitions for cores sitting on the internal 8-bit register bus.
//   rbusCtrl layout : {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}
//   rbusData        : 8-bit tri-state data
// Also holds the state type used by the multi-byte write register FSM.
// ---------------------------------------------------------------------------
package wca_rbus_pkg;

    localparam int RBUS_CLK      = 0;
    localparam int RBUS_STROBE   = 1;
    localparam int RBUS_WE       = 2;
    localparam int RBUS_RE       = 3;
    localparam int RBUS_ADDR_LSB = 4;
    localparam int RBUS_ADDR_MSB = 11;

    localparam int RBUS_DATA_W   = 8;
    localparam int RBUS_CTRL_W   = 12;

    typedef logic [RBUS_CTRL_W-1:0] rbus_ctrl_t;

    // Write FSM state. It is a view of the byte index: IDLE means the next
    // accepted byte is byte 0, FILL means a partial word is in the shadow.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/wca_rbus_decode.sv
// ---------------------------------------------------------------------------
// wca_rbus_decode
// Address/strobe decode shared by rbus register cores.
// Parameters:
//   MY_ADDR  : address matched against rbusCtrl[11:4]
// Ports:
//   rbus_ctrl in  12  raw rbus control word
//   sel       out 1   address matches
//   wr_beat   out 1   sel & writeEnable & dataStrobe
//   rd_beat   out 1   sel & readEnable & dataStrobe
// ---------------------------------------------------------------------------
module wca_rbus_decode
    import wca_rbus_pkg::*;
#(
    parameter logic [7:0] MY_ADDR = 8'h00
) (
    input  logic [11:0] rbus_ctrl,
    output logic        sel,
    output logic        wr_beat,
    output logic        rd_beat
);

    // The bus clock bit is carried on the control word but the cores run on
    // the dedicated clock input, so it is intentionally ignored here.
    logic unused_clkbus;
    assign unused_clkbus = rbus_ctrl[RBUS_CLK];

    assign sel     = (rbus_ctrl[RBUS_ADDR_MSB:RBUS_ADDR_LSB] == MY_ADDR);
    assign wr_beat = sel & rbus_ctrl[RBUS_WE] & rbus_ctrl[RBUS_STROBE];
    assign rd_beat = sel & rbus_ctrl[RBUS_RE] & rbus_ctrl[RBUS_STROBE];

endmodule

// File: rtl/wca_write_multi_reg.sv
// ---------------------------------------------------------------------------
// wca_write_multi_reg
// Multi-byte rbus write register. Bytes arrive LSB first on rbusData, are
// gathered in a shadow register, and are committed to `out` all at once when
// the last byte is written; `nd` pulses for one cycle together with the
// update. Dropping the address select mid-word discards the partial word.
//
// Parameters:
//   MY_ADDR      rbus address decoded from rbusCtrl[11:4]
//   WIDTH_BYTES  bytes per register, 1..8
//   RESET_VALUE  reset value of out and shadow
// Ports:
//   clock     in     1        core clock (rbus clock at integration)
//   reset     in     1        synchronous, active-high
//   rbusCtrl  in     12       {addr, readEnable, writeEnable, dataStrobe, clkbus}
//   rbusData  inout  8        bus data; only driven when readback is built
//   out       out    8*WB     committed value
//   nd        out    1        new-data pulse, same cycle as the out update
//
// Build option: define WCA_WRITE_REG_READBACK_EN to add coherent byte-wise
// readback of `out` on rbusData. Without it rbusData is never driven.
// ---------------------------------------------------------------------------
module wca_write_multi_reg
    import wca_rbus_pkg::*;
#(
    parameter logic [7:0]               MY_ADDR     = 8'h00,
    parameter int                       WIDTH_BYTES = 2,
    parameter logic [8*WIDTH_BYTES-1:0] RESET_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [11:0]                rbusCtrl,
    inout  wire  [7:0]                 rbusData,
    output logic [8*WIDTH_BYTES-1:0]   out,
    output logic                       nd
);

    localparam int         W    = 8 * WIDTH_BYTES;
    localparam logic [2:0] LAST = 3'(WIDTH_BYTES - 1);

    logic sel;
    logic wr_beat;
    logic rd_beat;

    wca_rbus_decode #(
        .MY_ADDR (MY_ADDR)
    ) u_decode (
        .rbus_ctrl (rbusCtrl),
        .sel       (sel),
        .wr_beat   (wr_beat),
        .rd_beat   (rd_beat)
    );

    logic [7:0]   rbus_in;
    assign rbus_in = rbusData;

    // -----------------------------------------------------------------------
    // Write FSM: the byte index is the state; `state` is its decoded view.
    // -----------------------------------------------------------------------
    logic [2:0]   widx, widx_n;
    logic [W-1:0] shadow, shadow_n;
    logic [W-1:0] out_n;
    logic         nd_n;
    wr_state_e    state;

    assign state = (widx == 3'd0) ? WR_IDLE : WR_FILL;

    always_ff @(posedge clock) begin
        if (reset) begin
            widx   <= 3'd0;
            shadow <= RESET_VALUE;
            out    <= RESET_VALUE;
            nd     <= 1'b0;
        end else begin
            widx   <= widx_n;
            shadow <= shadow_n;
            out    <= out_n;
            nd     <= nd_n;
        end
    end

    always_comb begin
        widx_n   = widx;
        shadow_n = shadow;
        out_n    = out;
        nd_n     = 1'b0;

        if (!sel) begin
            // Deselect abandons any partial word; the shadow bytes are simply
            // overwritten by the next transfer, which restarts at byte 0.
            widx_n = 3'd0;
        end else if (wr_beat) begin
            case (state)
                WR_IDLE: begin
                    shadow_n[7:0] = rbus_in;
                    widx_n        = (LAST == 3'd0) ? 3'd0 : 3'd1;
                end
                WR_FILL: begin
                    shadow_n[{widx, 3'b000} +: 8] = rbus_in;
                    widx_n                        = widx + 3'd1;
                end
                default: widx_n = 3'd0;
            endcase

            // The commit takes the freshly written top byte together with the
            // already gathered lower bytes, so out changes in a single edge.
            if (widx == LAST) begin
                out_n  = shadow_n;
                nd_n   = 1'b1;
                widx_n = 3'd0;
            end
        end
    end

`ifdef WCA_WRITE_REG_READBACK_EN
    // -----------------------------------------------------------------------
    // Readback: byte 0 comes straight from out, and the same edge that
    // accepts it snapshots out, so later bytes belong to the same word even
    // if a commit lands mid-sequence.
    // -----------------------------------------------------------------------
    logic [2:0]   ridx;
    logic [W-1:0] rsnap;
    logic [7:0]   rd_byte;
    logic         rd_drive;

    always_ff @(posedge clock) begin
        if (reset) begin
            ridx  <= 3'd0;
            rsnap <= RESET_VALUE;
        end else if (!sel) begin
            ridx  <= 3'd0;
        end else if (rd_beat && !wr_beat) begin
            // A write beat in the same cycle wins; ridx then holds.
            if (ridx == 3'd0) begin
                rsnap <= out;
            end
            ridx <= (ridx == LAST) ? 3'd0 : ridx + 3'd1;
        end
    end

    always_comb begin
        rd_byte = rsnap[{ridx, 3'b000} +: 8];
        if (ridx == 3'd0) begin
            rd_byte = out[7:0];
        end
    end

    assign rd_drive = sel & rbusCtrl[RBUS_RE];
    assign rbusData = rd_drive ? rd_byte : 8'hzz;
`else
    logic unused_rd_beat;
    assign unused_rd_beat = rd_beat;
    assign rbusData       = 8'hzz;
`endif

endmodule
